// File: rtl/adder_pkg.sv
// Shared types for the digit-serial adder/accumulator.
//   mode_e    : operation requested on in_mode
//   state_e   : control FSM states
//   width_ok  : configuration check used at elaboration by the top level
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Operand width must split into whole digits; digit must be at least 2 bits so the
  // carry into its MSB is distinct from the carry-in.
  function automatic bit width_ok(int unsigned width, int unsigned digit);
    return (digit >= 2) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder built from full-adder cells.
//   a, b      : digit operands
//   cin       : carry into bit 0
//   sum       : digit sum
//   cout      : carry out of the MSB
//   cmsb      : carry into the MSB (xor with cout gives signed overflow)
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : gen_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[DIGIT];
  assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder_acc.sv
// Digit-serial adder/subtractor/accumulator. WIDTH-bit operands are processed DIGIT bits
// per clock through a single digit_adder.
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready             : request handshake
//   in_a, in_b, in_cin, in_mode   : operands, carry-in, operation (ADD/SUB/ACC/CLR)
//   out_valid/out_ready           : result handshake
//   out_sum, out_cout, out_ovf    : registered result, carry-out, signed overflow
//   busy                          : operation in progress or result waiting
module serial_adder_acc
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!width_ok(WIDTH, DIGIT)) begin : gen_bad_cfg
    $error("serial_adder_acc: WIDTH must be a multiple of DIGIT with 2 <= DIGIT <= WIDTH");
  end

  state_e           state_q;
  mode_e            mode_q;
  mode_e            req_mode;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_dig;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;

  assign req_mode = mode_e'(in_mode);
  assign last_dig = (cnt_q == CntW'(NDIG - 1));
  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    dig_a    = a_q[cnt_q*DIGIT +: DIGIT];
    dig_b    = b_q[cnt_q*DIGIT +: DIGIT];
    // Full result including the digit being produced this cycle.
    res_next = res_q;
    res_next[cnt_q*DIGIT +: DIGIT] = dig_sum;
  end

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .cmsb (dig_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ADD;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mode_q  <= req_mode;
            cnt_q   <= '0;
            res_q   <= '0;
            state_q <= ST_RUN;
            unique case (req_mode)
              MODE_SUB: begin
                a_q     <= in_a;
                b_q     <= ~in_b;
                carry_q <= 1'b1;
              end
              MODE_ACC: begin
                a_q     <= acc_q;
                b_q     <= in_a;
                carry_q <= in_cin;
              end
              MODE_CLR: begin
                a_q     <= '0;
                b_q     <= '0;
                carry_q <= 1'b0;
              end
              default: begin
                a_q     <= in_a;
                b_q     <= in_b;
                carry_q <= in_cin;
              end
            endcase
          end
        end

        ST_RUN: begin
          if (mode_q == MODE_CLR) begin
            // CLR spends one cycle here so its result appears one edge after accept.
            acc_q     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            res_q   <= res_next;
            carry_q <= dig_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last_dig) begin
              out_sum   <= res_next;
              out_cout  <= dig_cout;
              out_ovf   <= dig_cmsb ^ dig_cout;
              out_valid <= 1'b1;
              state_q   <= ST_DONE;
              if (mode_q == MODE_ACC) begin
                acc_q <= res_next;
              end
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_acc.sv
module tb_serial_adder_acc;
  import adder_pkg::*;

  logic        clk;
  logic        rst;

  // 8-bit instance, DIGIT=4
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [7:0]  in_a, in_b, out_sum;
  logic [1:0]  in_mode;

  // 16-bit instance, DIGIT=4
  logic        w_in_valid, w_in_ready, w_in_cin, w_out_valid, w_out_ready;
  logic        w_out_cout, w_out_ovf, w_busy;
  logic [15:0] w_in_a, w_in_b, w_out_sum;
  logic [1:0]  w_in_mode;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_acc #(.WIDTH(8), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  serial_adder_acc #(.WIDTH(16), .DIGIT(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_a      (w_in_a),
    .in_b      (w_in_b),
    .in_cin    (w_in_cin),
    .in_mode   (w_in_mode),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_sum   (w_out_sum),
    .out_cout  (w_out_cout),
    .out_ovf   (w_out_ovf),
    .busy      (w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request on the 8-bit instance (called #1 after a rising edge, DUT idle),
  // wait for the result and consume it.
  task automatic op8(input string tag, input logic [1:0] mode, input logic [7:0] a,
                     input logic [7:0] b, input logic cin, input logic [7:0] exp_sum,
                     input logic exp_cout, input logic exp_ovf, input int exp_lat);
    int lat;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_eq({tag, ".ready_low"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".sum"}, 32'(out_sum), 32'(exp_sum));
    check_eq({tag, ".cout"}, 32'(out_cout), 32'(exp_cout));
    check_eq({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
    check_eq({tag, ".done_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".consumed"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  // One ADD or SUB on the 16-bit instance checked against a full-width arithmetic model.
  task automatic op16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic        exp_ovf;
    int          lat;
    bb      = sub ? ~b : b;
    c0      = sub ? 1'b1 : cin;
    full    = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    exp_ovf = (a[15] == bb[15]) && (full[15] != a[15]);
    w_in_mode  = sub ? MODE_SUB : MODE_ADD;
    w_in_a     = a;
    w_in_b     = b;
    w_in_cin   = cin;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("w.lat", 32'(lat), 32'd4);
    check_eq("w.sum", 32'(w_out_sum), 32'(full[15:0]));
    check_eq("w.cout", 32'(w_out_cout), 32'(full[16]));
    check_eq("w.ovf", 32'(w_out_ovf), 32'(exp_ovf));
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_mode = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_cin = 1'b0; w_in_mode = '0;
    w_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.out_sum", 32'(out_sum), 32'd0);
    check_eq("rst.cout_ovf", 32'({out_cout, out_ovf}), 32'd0);

    // ADD / SUB directed vectors
    op8("add_7f_01", MODE_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 2);
    op8("add_ff_01_c", MODE_ADD, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 2);
    op8("sub_05_07", MODE_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 2);
    op8("sub_80_01", MODE_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 2);

    // CLR then accumulate
    op8("clr", MODE_CLR, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1);
    op8("acc_10", MODE_ACC, 8'h10, 8'hEE, 1'b0, 8'h10, 1'b0, 1'b0, 2);
    op8("acc_25", MODE_ACC, 8'h25, 8'h00, 1'b0, 8'h35, 1'b0, 1'b0, 2);
    op8("acc_f0_c", MODE_ACC, 8'hF0, 8'h00, 1'b1, 8'h26, 1'b1, 1'b0, 2);

    // Backpressure: result held 5 cycles while a new request is presented
    in_mode = MODE_ADD; in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp.valid", 32'(out_valid), 32'd1);
    in_mode = MODE_ADD; in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp.hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp.hold_sum", 32'(out_sum), 32'h46);
      check_eq("bp.hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp.rel_valid", 32'(out_valid), 32'd0);
    check_eq("bp.rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("bp.no_accept", 32'(busy), 32'd0);

    // Reset pulse in the middle of an ACC (accumulator currently 0x26)
    in_mode = MODE_ACC; in_a = 8'h40; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("mrst.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check_eq("mrst.in_ready", 32'(in_ready), 32'd1);
    check_eq("mrst.out_sum", 32'(out_sum), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("mrst.no_valid", 32'(out_valid), 32'd0);
    end
    op8("acc_after_rst", MODE_ACC, 8'h03, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 2);

    // 16-bit instance: boundary vectors then random ADD/SUB
    op16(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    op16(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    op16(1'b1, 16'h0000, 16'h0001, 1'b0);
    op16(1'b1, 16'h8000, 16'h0001, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      op16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_acc.md
Name: serial_adder_acc

Overview:
- Parametrised digit-serial adder/subtractor/accumulator. Successor to the fixed 4-bit ripple adder.
- Processes WIDTH-bit operands DIGIT bits per clock through one reused digit adder.
- Supports add, subtract, accumulate and clear modes, with valid/ready handshakes on both sides.
- Sits between the pin-level input mux and the output register bank in the top-level wrapper.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; must be >= 2 and <= WIDTH.
- NDIG, WIDTH/DIGIT (derived, localparam), number of digit cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; used by ADD and ACC only
- in_mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (for SUB, 1 = no borrow)
- out_ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset and interface:
  - One clock domain (clk). Reset rst is asynchronous and active-high.
  - Reset clears state to IDLE and zeroes operand registers, digit counter, carry, accumulator, out_sum, out_cout, out_ovf and out_valid.
  - busy=0 after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b, mode and the effective carry.
  - ADD: b'=in_b, c0=in_cin.
  - SUB: b'=~in_b, c0=1; in_cin ignored.
  - ACC: a'=acc, b'=in_a, c0=in_cin; in_b ignored.
  - CLR: go straight to DONE next cycle with sum=0, cout=0, ovf=0; acc cleared on that edge.
  - All other modes go to RUN with counter=0.
- RUN:
  - Each cycle the digit adder sums digit[counter] of a' and b' with the carry register.
  - It writes the sum digit into result[counter*DIGIT +: DIGIT], updates carry, and increments counter.
  - On the last digit (counter==NDIG-1) it records cout and ovf = carry-into-MSB XOR carry-out of MSB, then goes to DONE.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - On out_ready the result is consumed and the FSM returns to IDLE.
  - ACC writes its result into acc on the RUN->DONE edge.
- Latency:
  - Request accepted at edge T: out_valid rises after edge T+NDIG for ADD/SUB/ACC, and after edge T+1 for CLR.
  - Throughput is one operation per NDIG+2 cycles with out_ready held high.
- in_ready=0 throughout RUN and DONE; in_valid is ignored there. No operand queue.
- in_valid and out_ready both high in DONE: the result is consumed, and the new request is taken only on the following IDLE cycle.
- Wrap-around is modulo 2^WIDTH and is flagged only via out_cout/out_ovf.
- Reset asserted mid-RUN aborts the operation; no partial result is ever presented and acc is cleared.
- Outputs are registered; no combinational path from in_* to out_*.

Decomposition:
- Package adder_pkg:
  - mode_e enum {MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR}.
  - state_e enum {ST_IDLE, ST_RUN, ST_DONE}.
  - An elaboration check that WIDTH % DIGIT == 0.
- Sub-module digit_adder:
  - Parametrised DIGIT-bit combinational ripple adder built from full-adder cells.
  - Outputs: sum, cout, and carry into its MSB (for overflow).
  - Instantiated once.

Test Plan (WIDTH=8, DIGIT=4):
- ADD a=0x7F b=0x01 cin=0 -> out_sum=0x80 cout=0 ovf=1; out_valid 2 cycles after accept, in_ready=0 meanwhile.
- ADD a=0xFF b=0x01 cin=1 -> 0x01 cout=1 ovf=0. SUB a=0x05 b=0x07 -> 0xFE cout=0 ovf=0. SUB a=0x80 b=0x01 -> 0x7F cout=1 ovf=1.
- CLR, then ACC in_a=0x10, ACC in_a=0x25, ACC in_a=0xF0 cin=1 -> results 0x10, 0x35, 0x26 with cout=1 on the third.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0, a new in_valid is not accepted; release -> IDLE next cycle.
- Reset pulse during RUN of ACC -> out_valid never rises, acc=0, in_ready=1 after rst deasserts; next ACC in_a=0x03 -> 0x03.
- Randomised ADD/SUB against a reference model for 1000 ops at WIDTH=16, DIGIT=4 -> exact match of sum, cout and ovf.
